// File: rtl/axi_lite_pkg.sv
// Shared AXI-lite definitions: LSU master state encoding and xRESP codes.
package axi_lite_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5
  } lsu_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_wait_timer.sv
// Per-state wait counter; flags expiry when a wait state has lasted TIMEOUT cycles.
// Latency: expired is a decode of the registered count, no input-to-output path.
// Backpressure: none; clr wins over inc, TIMEOUT=0 never expires.
module axi_wait_timer #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [31:0] LIMIT = 32'(TIMEOUT) - 32'd1;

  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  // Count is 0 on the first cycle of a state, so LIMIT marks its TIMEOUT-th cycle.
  assign expired = (TIMEOUT != 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/lsu_axi_master.sv
// CPU load/store request to single-beat AXI-lite master, one transaction outstanding.
// Latency: read >= 3 cycles acceptance-to-resp_valid; write >= 3 cycles.
// Backpressure: req_ready only in IDLE; AXI valids held stable until ready or timeout.
module lsu_axi_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] awaddr,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic        bvalid,
  output logic        bready,
  input  logic [1:0]  bresp
);

  lsu_state_t  state_q, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  wstrb_q;
  logic        err_q, aw_done_q, w_done_q, live_q;
  logic        req_hs, ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic        drain, waiting, expired, tmo;

  // live_q keeps the drain readies low while reset is asserted.
  assign req_ready = (state_q == IDLE) && live_q;
  assign drain     = (state_q == IDLE) && live_q && !req_valid;

  assign arvalid = (state_q == RD_ADDR);
  assign awvalid = (state_q == WR_REQ) && !aw_done_q;
  assign wvalid  = (state_q == WR_REQ) && !w_done_q;
  assign rready  = (state_q == RD_DATA) || drain;
  assign bready  = (state_q == WR_RESP) || drain;

  assign araddr = addr_q;
  assign awaddr = addr_q;
  assign wdata  = wdata_q;
  assign wstrb  = wstrb_q;

  assign resp_valid = (state_q == DONE);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q && (state_q == DONE);

  assign req_hs = req_valid && req_ready;
  assign ar_hs  = arvalid && arready;
  assign r_hs   = rvalid && rready;
  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign b_hs   = bvalid && bready;

  assign waiting = (state_q == RD_ADDR) || (state_q == RD_DATA) ||
                   (state_q == WR_REQ)  || (state_q == WR_RESP);

  axi_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_d != state_q),
    .inc     (waiting),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A completing handshake takes priority over a timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    tmo     = 1'b0;
    unique case (state_q)
      IDLE:    if (req_hs) state_d = req_wen ? WR_REQ : RD_ADDR;
      RD_ADDR: if (ar_hs) state_d = RD_DATA;
               else if (expired) begin state_d = DONE; tmo = 1'b1; end
      RD_DATA: if (r_hs) state_d = DONE;
               else if (expired) begin state_d = DONE; tmo = 1'b1; end
      WR_REQ:  if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WR_RESP;
               else if (expired) begin state_d = DONE; tmo = 1'b1; end
      WR_RESP: if (b_hs) state_d = DONE;
               else if (expired) begin state_d = DONE; tmo = 1'b1; end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      live_q    <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (req_hs) begin
        addr_q    <= req_addr;
        wdata_q   <= req_wdata;
        wstrb_q   <= req_wstrb;
        rdata_q   <= '0;
        err_q     <= 1'b0;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if (aw_hs) aw_done_q <= 1'b1;
      if (w_hs)  w_done_q  <= 1'b1;
      if ((state_q == RD_DATA) && r_hs) begin
        rdata_q <= (rresp == RESP_OKAY) ? rdata : '0;
        err_q   <= (rresp != RESP_OKAY);
      end
      if ((state_q == WR_RESP) && b_hs) begin
        rdata_q <= '0;
        err_q   <= (bresp != RESP_OKAY);
      end
      if (tmo) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master: reset, CLINT read, staggered write, errors, timeout, mid-write reset.
module tb_lsu_axi_master;
  import axi_lite_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_wen = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        arvalid, arready = 1'b0;
  logic [31:0] araddr;
  logic        rvalid = 1'b0, rready;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        awvalid, awready = 1'b0;
  logic [31:0] awaddr;
  logic        wvalid, wready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid = 1'b0, bready;
  logic [1:0]  bresp = '0;

  logic [63:0] mtime = 64'h0000_0000_0000_3A00;
  int n_checks = 0;
  int n_fail = 0;

  lsu_axi_master #(.TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) mtime <= mtime + 64'd1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cooperative slave: all readies high, R/B returned the cycle after the address/data handshakes.
  task automatic run_txn(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] ws, input logic [31:0] rd, input logic [1:0] rsp,
                         output logic [31:0] o_rdata, output logic o_err, output int lat,
                         output logic seen);
    logic ar_got, r_got, aw_got, w_got, b_got;
    int wait_cyc;
    ar_got = 1'b0; r_got = 1'b0; aw_got = 1'b0; w_got = 1'b0; b_got = 1'b0;
    o_rdata = '0; o_err = 1'b0; lat = 0; seen = 1'b0; wait_cyc = 0;
    while (req_ready !== 1'b1 && wait_cyc < 10) begin
      step();
      wait_cyc++;
    end
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wd; req_wstrb = ws;
    step();
    req_valid = 1'b0;
    arready = 1'b1; awready = 1'b1; wready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      if (resp_valid === 1'b1) begin
        seen = 1'b1; lat = i; o_rdata = resp_rdata; o_err = resp_err;
        break;
      end
      rvalid = ar_got && !r_got; rdata = rd; rresp = rsp;
      bvalid = aw_got && w_got && !b_got; bresp = rsp;
      #1;
      if (arvalid === 1'b1 && arready) ar_got = 1'b1;
      if (rvalid && rready === 1'b1) r_got = 1'b1;
      if (awvalid === 1'b1 && awready) aw_got = 1'b1;
      if (wvalid === 1'b1 && wready) w_got = 1'b1;
      if (bvalid && bready === 1'b1) b_got = 1'b1;
      step();
    end
    rvalid = 1'b0; bvalid = 1'b0; arready = 1'b0; awready = 1'b0; wready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) step();
    n_checks++;
    if ({arvalid, awvalid, wvalid, rready, bready, resp_valid, resp_err} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: ar/aw/w/r/b/resp/err=%b required 0000000",
               {arvalid, awvalid, wvalid, rready, bready, resp_valid, resp_err});
    end
    n_checks++;
    if ({resp_rdata, araddr, wdata, wstrb} !== 100'h0) begin
      n_fail++;
      $display("FAIL reset_data: rdata=%h addr=%h wdata=%h wstrb=%h required all 0",
               resp_rdata, araddr, wdata, wstrb);
    end
    rst_n = 1'b1;
    repeat (2) step();
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_req_ready: got %b required 1", req_ready);
    end
  endtask

  task automatic test_read_clint();
    logic [31:0] exp;
    repeat (5) step();
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h1001_0000;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rd_accept: req_ready=%b required 1", req_ready);
    end
    step();
    req_valid = 1'b0;
    n_checks++;
    if (arvalid !== 1'b1 || araddr !== 32'h1001_0000) begin
      n_fail++; $display("FAIL rd_ar: arvalid=%b araddr=%h required 1 10010000", arvalid, araddr);
    end
    exp = mtime[31:0];
    arready = 1'b1;
    step();
    arready = 1'b0;
    n_checks++;
    if (arvalid !== 1'b0 || rready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_data_phase: arvalid=%b rready=%b resp_valid=%b required 0 1 0",
               arvalid, rready, resp_valid);
    end
    rvalid = 1'b1; rdata = exp; rresp = RESP_OKAY;
    step();
    rvalid = 1'b0; rdata = '0;
    n_checks++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== exp) begin
      n_fail++;
      $display("FAIL rd_resp: valid=%b err=%b rdata=%h required 1 0 %h",
               resp_valid, resp_err, resp_rdata, exp);
    end
    step();
    n_checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_after: resp_valid=%b req_ready=%b required 0 1", resp_valid, req_ready);
    end
  endtask

  task automatic test_write_staggered();
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h1001_0010;
    req_wdata = 32'hDEAD_BEEF; req_wstrb = 4'hF;
    step();
    req_valid = 1'b0;
    n_checks++;
    if (awvalid !== 1'b1 || wvalid !== 1'b1 || awaddr !== 32'h1001_0010 ||
        wdata !== 32'hDEAD_BEEF || wstrb !== 4'hF) begin
      n_fail++;
      $display("FAIL wr_first: aw=%b w=%b awaddr=%h wdata=%h wstrb=%h required 1 1 10010010 deadbeef f",
               awvalid, wvalid, awaddr, wdata, wstrb);
    end
    wready = 1'b1;
    step();
    wready = 1'b0;
    n_checks++;
    if (wvalid !== 1'b0 || awvalid !== 1'b1) begin
      n_fail++; $display("FAIL wr_w_drop: wvalid=%b awvalid=%b required 0 1", wvalid, awvalid);
    end
    step();
    n_checks++;
    if (awvalid !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL wr_aw_hold: awvalid=%b resp_valid=%b required 1 0", awvalid, resp_valid);
    end
    awready = 1'b1;
    step();
    awready = 1'b0;
    n_checks++;
    if (awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_resp_phase: aw=%b w=%b bready=%b required 0 0 1", awvalid, wvalid, bready);
    end
    bvalid = 1'b1; bresp = RESP_OKAY;
    step();
    bvalid = 1'b0;
    n_checks++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL wr_resp: valid=%b err=%b rdata=%h required 1 0 0", resp_valid, resp_err, resp_rdata);
    end
    step();
    n_checks++;
    if (resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL wr_single_pulse: resp_valid=%b required 0", resp_valid);
    end
  endtask

  task automatic test_read_slverr();
    logic [31:0] d; logic e, seen; int lat;
    run_txn(1'b0, 32'h1001_0008, 32'h0, 4'h0, 32'hCAFE_F00D, RESP_SLVERR, d, e, lat, seen);
    n_checks++;
    if (seen !== 1'b1 || e !== 1'b1 || d !== 32'h0 || lat != 3) begin
      n_fail++;
      $display("FAIL rd_slverr: seen=%b err=%b rdata=%h lat=%0d required 1 1 0 3", seen, e, d, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic e, seen; int lat;
    run_txn(1'b1, 32'h1001_0004, 32'h0000_00A5, 4'h1, 32'h0, RESP_DECERR, d, e, lat, seen);
    n_checks++;
    if (seen !== 1'b1 || e !== 1'b1 || d !== 32'h0 || lat != 3) begin
      n_fail++;
      $display("FAIL wr_decerr_same_cycle: seen=%b err=%b rdata=%h lat=%0d required 1 1 0 3",
               seen, e, d, lat);
    end
    step();
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_ready: req_ready=%b required 1", req_ready);
    end
    run_txn(1'b0, 32'h1001_000C, 32'h0, 4'h0, 32'h1357_9BDF, RESP_OKAY, d, e, lat, seen);
    n_checks++;
    if (seen !== 1'b1 || e !== 1'b0 || d !== 32'h1357_9BDF || lat != 3) begin
      n_fail++;
      $display("FAIL b2b_read: seen=%b err=%b rdata=%h lat=%0d required 1 0 13579bdf 3", seen, e, d, lat);
    end
  endtask

  task automatic test_timeout();
    int bad_cyc;
    int pulses;
    step();
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h1001_0100;
    step();
    req_valid = 1'b0;
    bad_cyc = 0;
    for (int i = 1; i <= 8; i++) begin
      if ((arvalid !== 1'b1 || resp_valid !== 1'b0) && bad_cyc == 0) bad_cyc = i;
      step();
    end
    n_checks++;
    if (bad_cyc != 0) begin
      n_fail++; $display("FAIL tmo_wait: early change at cycle %0d required none", bad_cyc);
    end
    n_checks++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0 || arvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_resp: valid=%b err=%b rdata=%h arvalid=%b required 1 1 0 0",
               resp_valid, resp_err, resp_rdata, arvalid);
    end
    step();
    n_checks++;
    if (arvalid !== 1'b0 || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL tmo_after: arvalid=%b resp_valid=%b required 0 0", arvalid, resp_valid);
    end
    rvalid = 1'b1; rdata = 32'hBAD0_BAD0; rresp = RESP_OKAY;
    #1;
    n_checks++;
    if (rready !== 1'b1) begin
      n_fail++; $display("FAIL late_rready: rready=%b required 1", rready);
    end
    step();
    rvalid = 1'b0;
    pulses = 0;
    repeat (4) begin
      if (resp_valid === 1'b1) pulses++;
      step();
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++; $display("FAIL late_discard: resp_valid pulses=%0d required 0", pulses);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] d; logic e, seen; int lat; int pulses;
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h1001_0020;
    req_wdata = 32'h5A5A_5A5A; req_wstrb = 4'hF;
    step();
    req_valid = 1'b0;
    awready = 1'b1; wready = 1'b1;
    step();
    awready = 1'b0; wready = 1'b0;
    n_checks++;
    if (bready !== 1'b1) begin
      n_fail++; $display("FAIL rst_setup_wr_resp: bready=%b required 1", bready);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({arvalid, awvalid, wvalid, rready, bready, resp_valid} !== 6'b0) begin
      n_fail++;
      $display("FAIL rst_async: ar/aw/w/r/b/resp=%b required 000000",
               {arvalid, awvalid, wvalid, rready, bready, resp_valid});
    end
    step();
    step();
    rst_n = 1'b1;
    pulses = 0;
    repeat (4) begin
      if (resp_valid === 1'b1) pulses++;
      step();
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++; $display("FAIL rst_no_resp: resp_valid pulses=%0d required 0", pulses);
    end
    run_txn(1'b0, 32'h1001_0000, 32'h0, 4'h0, 32'h2468_ACE0, RESP_OKAY, d, e, lat, seen);
    n_checks++;
    if (seen !== 1'b1 || e !== 1'b0 || d !== 32'h2468_ACE0 || lat != 3) begin
      n_fail++;
      $display("FAIL rst_recover: seen=%b err=%b rdata=%h lat=%0d required 1 0 2468ace0 3", seen, e, d, lat);
    end
  endtask

  initial begin
    test_reset();
    test_read_clint();
    test_write_staggered();
    test_read_slverr();
    test_back_to_back();
    test_timeout();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
